// File: rtl/mem_arbiter.sv
// Arbitrates a multi-cycle unified memory between an instruction-fetch port and a data port.
// Optional macro ARB_RR_EN: round-robin tie-break; default is fixed D-over-I priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_owner;
  logic               w_grant_d;

`ifdef ARB_RR_EN
  logic r_last_grant;
  // On a tie, D wins only if I was granted last.
  assign w_grant_d = d_req && (!i_req || (r_last_grant == OWN_I));
`else
  assign w_grant_d = d_req;
`endif

  // Arbitration, access sequencing and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner    <= OWN_D;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
`ifdef ARB_RR_EN
      r_last_grant <= OWN_D;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            r_owner    <= w_grant_d ? OWN_D : OWN_I;
            mem_addr   <= w_grant_d ? d_addr : i_addr;
            mem_wdata  <= w_grant_d ? d_wdata : '0;
            mem_wr     <= w_grant_d && d_wr;
            mem_enable <= 1'b1;
            busy       <= 1'b1;
            r_cnt      <= CNT_W'(MEM_LATENCY - 1);
            r_state    <= S_ACCESS;
`ifdef ARB_RR_EN
            r_last_grant <= w_grant_d ? OWN_D : OWN_I;
`endif
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            // Last access cycle: read data is valid now.
            if (r_owner == OWN_I) begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              if (!mem_wr) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter at MEM_LATENCY=4.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LAT    = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_wr = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval starting just after rising edge n.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({i_ack, d_ack, mem_enable, mem_wr, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000", {i_ack, d_ack, mem_enable, mem_wr, busy});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    logic [3:0] exp, got;
    i_req = 1'b1; i_addr = 16'h0010; mem_rdata = 16'hA5A5;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = {(c <= 4), 1'b0, (c == 5), (c <= 5)};
      got = {mem_enable, mem_wr, i_ack, busy};
      n_checks++;
      if (got !== exp || d_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_c%0d: en/wr/iack/busy got %b dack %b required %b dack 0", c, got, d_ack, exp);
      end
      if (c == 1) begin
        n_checks++;
        if (mem_addr !== 16'h0010) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h required 0010", mem_addr);
        end
      end
    end
    n_checks++;
    if (i_rdata !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h required a5a5", i_rdata);
    end
    i_req = 1'b0;
    tick();
    n_checks++;
    if ({busy, mem_enable} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_regrant: busy/en got %b required 00", {busy, mem_enable});
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({mem_enable, mem_wr, d_ack, i_ack} !== {(c <= 4), (c <= 4), (c == 5), 1'b0}) begin
        n_fail++;
        $display("FAIL store_ctrl_c%0d: en/wr/dack/iack got %b required %b", c,
                 {mem_enable, mem_wr, d_ack, i_ack}, {(c <= 4), (c <= 4), (c == 5), 1'b0});
      end
      if (c <= 4) begin
        n_checks++;
        if (mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL store_bus_c%0d: addr %h wdata %h required 0200 1234", c, mem_addr, mem_wdata);
        end
      end
    end
    d_req = 1'b0; d_wr = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    logic exp_i, exp_d;
    do_reset();
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0220;
    mem_rdata = 16'h7777;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_i = RR ? (c == 5) : (c == 11);
      exp_d = RR ? (c == 11) : (c == 5);
      n_checks++;
      if ({i_ack, d_ack} !== {exp_i, exp_d}) begin
        n_fail++;
        $display("FAIL tie_c%0d: iack/dack got %b required %b", c, {i_ack, d_ack}, {exp_i, exp_d});
      end
      if (c == 6) begin
        if (RR) i_req = 1'b0;
        else d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_continuous_d();
    logic exp_ack, exp_i, exp_d, exp_b;
    do_reset();
    i_req = 1'b1; i_addr = 16'h0030;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0330;
    for (int c = 1; c <= 24; c++) begin
      tick();
      exp_ack = (c % 6 == 5);
      exp_i   = RR ? (exp_ack && ((c / 6) % 2 == 0)) : 1'b0;
      exp_d   = exp_ack && !exp_i;
      exp_b   = (c % 6 != 0);
      n_checks++;
      if ({i_ack, d_ack, busy} !== {exp_i, exp_d, exp_b}) begin
        n_fail++;
        $display("FAIL cont_c%0d: iack/dack/busy got %b required %b", c,
                 {i_ack, d_ack, busy}, {exp_i, exp_d, exp_b});
      end
      if (c == 24) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 16'h0040; mem_rdata = 16'h1111;
    tick();
    tick();
    n_checks++;
    if ({mem_enable, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_pre: en/busy got %b required 11", {mem_enable, busy});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_enable, busy, i_ack, d_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: en/busy/iack/dack got %b required 0000", {mem_enable, busy, i_ack, d_ack});
    end
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({i_ack, d_ack, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_noack_c%0d: iack/dack/busy got %b required 000", c, {i_ack, d_ack, busy});
      end
    end
    i_req = 1'b1; i_addr = 16'h0050; mem_rdata = 16'h5A5A;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if (i_ack !== (c == 5)) begin
        n_fail++;
        $display("FAIL rstmid_after_c%0d: iack got %b required %b", c, i_ack, (c == 5));
      end
    end
    n_checks++;
    if (i_rdata !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL rstmid_rdata: got %h required 5a5a", i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_load_then_fetch();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300; mem_rdata = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({d_ack, i_ack, mem_wr} !== {(c == 5), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL load_c%0d: dack/iack/wr got %b required %b", c, {d_ack, i_ack, mem_wr}, {(c == 5), 2'b00});
      end
    end
    n_checks++;
    if (d_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL load_rdata: got %h required beef", d_rdata);
    end
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 16'h0060; mem_rdata = 16'h0F0F;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({i_ack, d_ack} !== {(c == 5), 1'b0}) begin
        n_fail++;
        $display("FAIL fetch2_c%0d: iack/dack got %b required %b", c, {i_ack, d_ack}, {(c == 5), 1'b0});
      end
    end
    n_checks++;
    if (i_rdata !== 16'h0F0F || d_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL load_hold: i_rdata %h d_rdata %h required 0f0f beef", i_rdata, d_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  // Both acks high together is never legal.
  always @(negedge clk) begin
    if (!rst && i_ack && d_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_excl: iack=1 dack=1 required at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_continuous_d();
    test_reset_mid();
    test_load_then_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
